// File: rtl/tdm_transmission.sv
// TDM channel: pointer-driven MUX onto a registered line, DMUX back into slots.
// Define TDM_TRANSMISSION_SNAPSHOT_EN to publish oData only at frame boundaries.
module tdm_transmission #(
  parameter  int CHANNELS = 8,
  parameter  int WIDTH    = 1,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iEn,
  input  logic                      iMode,
  input  logic [SELW-1:0]           iSel,
  input  logic [CHANNELS*WIDTH-1:0] iData,
  output logic [WIDTH-1:0]          oLine,
  output logic [SELW-1:0]           oTag,
  output logic                      oLineVld,
  output logic [CHANNELS*WIDTH-1:0] oData,
  output logic                      oFrame
);

  localparam logic [SELW:0]   CH_W = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]           ptr;
  logic [SELW-1:0]           idx;
  logic                      legal;
  logic [WIDTH-1:0]          word;
  logic                      line_scan;
  logic                      frame_hit;
  logic [CHANNELS*WIDTH-1:0] base;
  logic [CHANNELS*WIDTH-1:0] landed;

`ifdef TDM_TRANSMISSION_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] shadow;
  assign base = shadow;
`else
  assign base = oData;
`endif

  always_comb begin
    idx   = iMode ? iSel : ptr;
    legal = {1'b0, idx} < CH_W;
    word  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) word = iData[k*WIDTH +: WIDTH];
    end
  end

  // The in-flight word lands regardless of iEn.
  always_comb begin
    landed = base;
    if (oLineVld) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (oTag == SELW'(k)) landed[k*WIDTH +: WIDTH] = oLine;
      end
    end
  end

  assign frame_hit = oLineVld && line_scan && (oTag == LAST);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr       <= '0;
      oLine     <= '0;
      oTag      <= '0;
      oLineVld  <= 1'b0;
      line_scan <= 1'b0;
      oData     <= '0;
      oFrame    <= 1'b0;
`ifdef TDM_TRANSMISSION_SNAPSHOT_EN
      shadow    <= '0;
`endif
    end else begin
      if (iEn && !iMode) begin
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
      if (iEn && legal) begin
        oLine     <= word;
        oTag      <= idx;
        oLineVld  <= 1'b1;
        line_scan <= ~iMode;
      end else begin
        oLineVld  <= 1'b0;
      end
      oFrame <= frame_hit;
`ifdef TDM_TRANSMISSION_SNAPSHOT_EN
      shadow <= landed;
      if (frame_hit) oData <= landed;
`else
      oData  <= landed;
`endif
    end
  end

endmodule

// File: doc/tdm_transmission.md
# tdm_transmission

Parametrised time-division multiplexed transmission channel for the MUX/DMUX experiment family. A channel pointer scans CHANNELS parallel input words. A MUX stage puts the selected word onto a registered shared line, and a DMUX stage writes the line back into the matching output slot. This makes the N-way parallel-to-parallel transfer a real serial-bus transfer with framing, an enable and a manual-select mode.

## Interface
Parameters:
- CHANNELS, 8 — number of channels; legal range 2..64, non-power-of-two allowed.
- WIDTH, 1 — bits per channel word.
- SELW, $clog2(CHANNELS) — select/tag width; derived, not overridden.

Ports:
- iClk  input  1  — single clock; all state changes on its rising edge.
- iRst_n  input  1  — reset, asynchronous, active-low.
- iEn  input  1  — transfer enable; low freezes all state.
- iMode  input  1  — 0 selects scan mode (pointer auto-advances); 1 selects manual mode (iSel picks the channel).
- iSel  input  SELW  — manual channel select; values ≥ CHANNELS are ignored, and no transfer is launched.
- iData  input  CHANNELS*WIDTH  — channel k occupies bits [k*WIDTH +: WIDTH].
- oLine  output  WIDTH  — registered shared-line word.
- oTag  output  SELW  — channel index of the word on oLine.
- oLineVld  output  1  — oLine/oTag hold a valid transfer.
- oData  output  CHANNELS*WIDTH  — demultiplexed output slots, same packing as iData.
- oFrame  output  1  — one-cycle pulse when channel CHANNELS-1 is written to oData in scan mode.

## Operation
- **Pointer ptr (SELW bits).**
  - In scan mode with iEn=1, ptr advances by 1 each cycle and wraps from CHANNELS-1 to 0.
  - In manual mode, ptr holds its value.
  - When scan mode resumes, scanning continues from the held ptr.
- **Launch index.**
  - The launch index is ptr in scan mode and iSel in manual mode.
- **MUX stage.**
  - With iEn=1 and a legal index, the MUX stage registers iData[index] into oLine and index into oTag, and sets oLineVld=1.
  - Otherwise oLineVld is set to 0, and oLine/oTag hold their values.
- **DMUX stage.**
  - When oLineVld=1 at an edge, oLine is written to slot oTag; all other slots hold.
  - The write takes place even if iEn has dropped that cycle, so the in-flight word always lands.
- **oFrame.**
  - oFrame is high for the cycle after the slot CHANNELS-1 write, but only if that word was launched in scan mode.
  - Manual-mode launches never raise oFrame; the launch mode is carried with the word in the pipeline.
- **iEn=0.**
  - No new launch occurs, and ptr holds its value.
  - oData holds its value, except for the single in-flight write.
- **Asynchronous reset.**
  - On reset, ptr=0, oLine=0, oTag=0, oLineVld=0, oData=0 and oFrame=0.
  - Reset mid-frame discards the in-flight word, and the next frame starts at channel 0.

## Timing
- **Latency.** iData is sampled at edge N and appears on oLine/oTag at edge N. It appears in its oData slot at edge N+1, so it is visible two cycles after the launch cycle begins.
- **Throughput.** One channel per cycle.
- **Frame period.** A full frame takes CHANNELS cycles in continuous scan mode.
- **oFrame.** oFrame is asserted in the same cycle that slot CHANNELS-1 becomes visible on oData.
- **Mode switch.** iMode is sampled at each edge. The switch takes effect on the next launch; there are no bubbles, and the in-flight word completes.
- **Illegal iSel.** An iSel value ≥ CHANNELS produces a bubble (oLineVld=0) that cycle.

## Configuration
- **Macro:** TDM_TRANSMISSION_SNAPSHOT_EN.
- **Undefined:** each slot of oData updates as soon as its word lands, so oData mixes words from the current and previous frame.
- **Defined:**
  - Landing words go to an internal shadow buffer instead of oData.
  - oData is loaded from the shadow buffer, including the word landing in that same cycle, only on a scan-mode slot CHANNELS-1 write.
  - oData changes in the same cycle oFrame pulses.
  - Manual-mode writes go to the shadow buffer only and reach oData at the next frame boundary.
  - Reset clears the shadow buffer as well.

## Test plan
- **Reset values.** Assert iRst_n=0 mid-scan with iData=8'hA5 -> all outputs are 0 immediately, without waiting for a clock. After release with iEn=1 and scan mode, oTag=0 on the first edge.
- **Scan mode.** Default parameters, iData=8'b10110010, iEn=1, scan mode -> oTag steps 0..7 and then wraps to 0. oData equals 8'b10110010 after 9 edges. oFrame pulses once every 8 cycles.
- **Manual mode.** CHANNELS=5, WIDTH=4, iData=20'h1234F, iMode=1, iSel=3 -> oLine=4'h2 and oTag=3. Only slot 3 of oData becomes 4'h2. oFrame stays 0.
- **Illegal select.** CHANNELS=5, iSel=6 -> oLineVld=0 and oData is unchanged.
- **Enable pause.** Drop iEn for 3 cycles after tag 2 launches -> slot 2 still lands, ptr holds, and scan resumes with tag 3. The frame takes 11 cycles.
- **Snapshot build.** With TDM_TRANSMISSION_SNAPSHOT_EN, change iData from 8'h00 to 8'hFF at channel 4 -> oData stays 8'h00 until the oFrame cycle. It then jumps to 8'hF0 and reads 8'hFF after the next frame.
